bfp_compress_blk: RTL and testbench

Parametrised block-floating-point (BFP) compressor for the PUSCH dimension-reduction datapath. It takes a stream of complex IQ samples grouped into fixed-size blocks (one PRB of REs by default). For each block it computes one shared exponent and emits a rounded, saturated MW-bit mantissa per component, with all sideband fields delayed to stay aligned. It adds two capabilities over the previous fixed 7-bit compressor: configurable widths and block size, and a per-block fixed-exponent mode. It also performs protocol checking on block length.

---
 rtl/bfp_compress_blk.sv | 185 ++++++++++++++++++
 tb/tb_bfp_compress_blk.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bfp_compress_blk.sv
// Block-floating-point compressor: one shared exponent per NSAMP-sample block, rounded and
// saturated MW-bit mantissas, sidebands delayed NSAMP+4 cycles to stay aligned with the data.
module bfp_compress_blk #(
    parameter int unsigned IW    = 16,
    parameter int unsigned MW    = 7,
    parameter int unsigned NSAMP = 12,
    parameter int unsigned EW    = $clog2(IW - MW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic              i_sop,
    input  logic              i_eop,
    input  logic [2*IW-1:0]   i_din,
    input  logic              i_mode,
    input  logic [EW-1:0]     i_fix_exp,
    input  logic [6:0]        i_slot_idx,
    input  logic [3:0]        i_symb_idx,
    input  logic [8:0]        i_prb_idx,
    input  logic [3:0]        i_ch_type,
    input  logic [7:0]        i_info,
    output logic              o_vld,
    output logic              o_sop,
    output logic              o_eop,
    output logic [2*MW-1:0]   o_dout,
    output logic [EW-1:0]     o_exp,
    output logic [6:0]        o_slot_idx,
    output logic [3:0]        o_symb_idx,
    output logic [8:0]        o_prb_idx,
    output logic [3:0]        o_type,
    output logic [7:0]        o_info,
    output logic              o_len_err
);

    localparam int unsigned SH  = IW - MW;
    localparam int unsigned WW  = IW + SH;
    localparam int unsigned DLY = NSAMP + 2;
    localparam int unsigned CW  = $clog2(NSAMP + 1);
    localparam int unsigned SBW = 32;
    localparam int unsigned PW  = 3 + 2 * IW + SBW;
    localparam int unsigned RW  = MW + 3;
    localparam logic [MW-1:0] MaxPos = {1'b0, {(MW - 1){1'b1}}};
    localparam logic [MW-1:0] MaxNeg = {1'b1, {(MW - 1){1'b0}}};

    // {overflow, sign of x, y[IW-1:IW-MW-1]} for one component after the block shift
    function automatic logic [RW-1:0] pre(input logic [IW-1:0] x, input logic [EW-1:0] s);
        logic [WW-1:0] yw;
        logic          ovf;
        yw  = {{SH{x[IW-1]}}, x} << s;
        ovf = (yw[WW-1:IW-1] != {(SH + 1){yw[IW-1]}});
        return {ovf, x[IW-1], yw[IW-1:IW-MW-1]};
    endfunction

    function automatic logic [MW-1:0] rnd(input logic [RW-1:0] p);
        logic [MW-1:0] m;
        m = p[MW:1];
        if (p[MW+2])                return p[MW+1] ? MaxNeg : MaxPos;
        else if (p[0] && m == MaxPos) return MaxPos;
        else                        return m + MW'(p[0]);
    endfunction

    // Block-protocol tracking
    logic          open_q, open_d, err_q, err_d;
    logic [CW-1:0] idx_q, idx_d, cur_idx;

    always_comb begin
        cur_idx = i_sop ? '0 : idx_q;
        open_d  = open_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (i_vld) begin
            if (i_sop && open_q) err_d = 1'b1;
            if (!i_sop && !open_q) err_d = 1'b1;
            if (i_eop != (cur_idx == CW'(NSAMP - 1))) err_d = 1'b1;
            if (i_eop || cur_idx == CW'(NSAMP - 1)) begin
                open_d = 1'b0;
                idx_d  = '0;
            end else if (i_sop || open_q) begin
                open_d = 1'b1;
                idx_d  = cur_idx + CW'(1);
            end
        end else if (open_q) begin
            err_d  = 1'b1;
            open_d = 1'b0;
            idx_d  = '0;
        end
    end

    // Max accumulator; MSB of a one's-complement magnitude is always zero so it is dropped
    logic [IW-2:0] mag_iq, acc_q;
    logic          mode_q, done_q;
    logic [EW-1:0] fix_q, blk_sh_q, blk_exp_q, new_sh, new_exp;
    int            lz, s0, fix_e;

    assign mag_iq = (i_din[2*IW-1] ? ~i_din[2*IW-2:IW] : i_din[2*IW-2:IW])
                  | (i_din[IW-1] ? ~i_din[IW-2:0] : i_din[IW-2:0]);

    always_comb begin
        lz = int'(IW) - 1;
        for (int i = 0; i < int'(IW) - 1; i++) begin
            if (acc_q[i]) lz = int'(IW) - 2 - i;
        end
        fix_e   = (int'(fix_q) > int'(SH)) ? int'(SH) : int'(fix_q);
        s0      = (lz < int'(SH)) ? lz : int'(SH);
        new_sh  = EW'(s0);
        new_exp = EW'(int'(SH) - s0);
        if (mode_q) begin
            new_sh  = EW'(int'(SH) - fix_e);
            new_exp = EW'(fix_e);
        end
    end

    // Delay line holding samples until their block exponent is known
    logic [PW-1:0]   dly_q [DLY];
    logic            t_vld, t_sop, t_eop;
    logic [IW-1:0]   t_i, t_q;
    logic [SBW-1:0]  t_sb;
    logic [EW-1:0]   apply_sh_q, apply_exp_q, eff_sh, eff_exp;

    assign {t_vld, t_sop, t_eop, t_i, t_q, t_sb} = dly_q[DLY-1];
    assign eff_sh  = (t_vld && t_sop) ? blk_sh_q  : apply_sh_q;
    assign eff_exp = (t_vld && t_sop) ? blk_exp_q : apply_exp_q;

    logic            s1_vld, s1_sop, s1_eop;
    logic [RW-1:0]   s1_pi, s1_pq;
    logic [EW-1:0]   s1_exp;
    logic [SBW-1:0]  s1_sb;

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q      <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            mode_q      <= 1'b0;
            fix_q       <= '0;
            done_q      <= 1'b0;
            blk_sh_q    <= '0;
            blk_exp_q   <= '0;
            apply_sh_q  <= '0;
            apply_exp_q <= '0;
            for (int i = 0; i < int'(DLY); i++) dly_q[i] <= '0;
            {s1_vld, s1_sop, s1_eop, s1_pi, s1_pq, s1_exp, s1_sb} <= '0;
            {o_vld, o_sop, o_eop, o_dout, o_exp} <= '0;
            {o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info} <= '0;
            o_len_err   <= 1'b0;
        end else begin
            open_q <= open_d;
            idx_q  <= idx_d;
            err_q  <= err_d;
            done_q <= i_vld & i_eop;
            if (i_vld) acc_q <= i_sop ? mag_iq : (acc_q | mag_iq);
            if (i_vld && i_sop) begin
                mode_q <= i_mode;
                fix_q  <= i_fix_exp;
            end
            if (done_q) begin
                blk_sh_q  <= new_sh;
                blk_exp_q <= new_exp;
            end
            dly_q[0] <= {i_vld, i_sop, i_eop, i_din,
                         i_slot_idx, i_symb_idx, i_prb_idx, i_ch_type, i_info};
            for (int i = 1; i < int'(DLY); i++) dly_q[i] <= dly_q[i-1];
            if (t_vld) begin
                apply_sh_q  <= eff_sh;
                apply_exp_q <= eff_exp;
            end
            s1_vld <= t_vld;
            s1_sop <= t_sop;
            s1_eop <= t_eop;
            s1_pi  <= pre(t_i, eff_sh);
            s1_pq  <= pre(t_q, eff_sh);
            s1_exp <= eff_exp;
            s1_sb  <= t_sb;
            o_vld  <= s1_vld;
            o_sop  <= s1_sop;
            o_eop  <= s1_eop;
            o_dout <= {rnd(s1_pi), rnd(s1_pq)};
            if (s1_vld) o_exp <= s1_exp;
            {o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info} <= s1_sb;
            o_len_err <= err_d;
        end
    end

endmodule

// File: tb/tb_bfp_compress_blk.sv
// Directed bench for bfp_compress_blk: hand-computed mantissas/exponents, exact-latency checks.
module tb_bfp_compress_blk;

    localparam int IW = 16, MW = 7, NSAMP = 12, EW = 4, LAT = NSAMP + 4;

    logic clk, rst, i_vld, i_sop, i_eop, i_mode;
    logic [2*IW-1:0] i_din;
    logic [EW-1:0] i_fix_exp, o_exp;
    logic [6:0] i_slot_idx, o_slot_idx;
    logic [3:0] i_symb_idx, o_symb_idx, i_ch_type, o_type;
    logic [8:0] i_prb_idx, o_prb_idx;
    logic [7:0] i_info, o_info;
    logic o_vld, o_sop, o_eop, o_len_err;
    logic [2*MW-1:0] o_dout;

    bfp_compress_blk #(.IW(IW), .MW(MW), .NSAMP(NSAMP)) dut (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop), .i_din(i_din),
        .i_mode(i_mode), .i_fix_exp(i_fix_exp), .i_slot_idx(i_slot_idx),
        .i_symb_idx(i_symb_idx), .i_prb_idx(i_prb_idx), .i_ch_type(i_ch_type),
        .i_info(i_info), .o_vld(o_vld), .o_sop(o_sop), .o_eop(o_eop), .o_dout(o_dout),
        .o_exp(o_exp), .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx),
        .o_prb_idx(o_prb_idx), .o_type(o_type), .o_info(o_info), .o_len_err(o_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic            sop, eop, dchk;
        logic [2*MW-1:0] dout;
        logic [EW-1:0]   ex;
        logic [31:0]     sb;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0, cyc = 0, blk_id = 0;
    logic [IW-1:0] vi[NSAMP], vq[NSAMP];
    logic [MW-1:0] ei[NSAMP], eq[NSAMP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] sbf(input int b, input int k);
        return {7'(b), 4'(k), 9'(b * 16 + k), 4'(b ^ k), 8'(k * 3 + b)};
    endfunction

    // One clock; checks every output beat against the expected queue at its exact cycle
    task automatic step();
        exp_t e;
        logic want;
        @(posedge clk);
        #1;
        cyc++;
        want = (q.size() > 0) && (q[0].cyc == cyc);
        chk("o_vld", 32'(o_vld), 32'(want));
        if (want && o_vld) begin
            e = q.pop_front();
            chk("o_sop", 32'(o_sop), 32'(e.sop));
            chk("o_eop", 32'(o_eop), 32'(e.eop));
            chk("sideband", {o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info}, e.sb);
            if (e.dchk) begin
                chk("o_dout", 32'(o_dout), 32'(e.dout));
                chk("o_exp", 32'(o_exp), 32'(e.ex));
            end
        end
    endtask

    task automatic clear_blk();
        for (int k = 0; k < NSAMP; k++) begin
            vi[k] = '0; vq[k] = '0; ei[k] = '0; eq[k] = '0;
        end
    endtask

    task automatic idle(input int n);
        i_vld = 0; i_sop = 0; i_eop = 0; i_din = '0;
        repeat (n) step();
    endtask

    // Sends beats 0..n-1 with eop on beat eop_at; expected values come from ei/eq/ex
    task automatic send_blk(input logic mode, input logic [EW-1:0] fix, input logic [EW-1:0] ex,
                            input int n, input int eop_at, input logic dchk);
        exp_t e;
        i_mode = mode;
        i_fix_exp = fix;
        for (int k = 0; k < n; k++) begin
            i_vld = 1;
            i_sop = (k == 0);
            i_eop = (k == eop_at);
            i_din = {vi[k], vq[k]};
            {i_slot_idx, i_symb_idx, i_prb_idx, i_ch_type, i_info} = sbf(blk_id, k);
            e.cyc = cyc + LAT; e.sop = i_sop; e.eop = i_eop; e.dchk = dchk;
            e.dout = {ei[k], eq[k]}; e.ex = ex; e.sb = sbf(blk_id, k);
            q.push_back(e);
            step();
        end
        blk_id++;
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (q.size() > 0 && n < 4 * LAT) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1; i_vld = 0; i_sop = 0; i_eop = 0; i_din = '0; i_mode = 0; i_fix_exp = '0;
        {i_slot_idx, i_symb_idx, i_prb_idx, i_ch_type, i_info} = '0;
        step();
        step();
        chk("rst_dout", 32'(o_dout), 0);
        chk("rst_exp", 32'(o_exp), 0);
        chk("rst_len_err", 32'(o_len_err), 0);
        chk("rst_sop_eop", {o_sop, o_eop}, 0);
        chk("rst_sb", {o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info}, 0);
        rst = 0;
        idle(2);

        // All-zero block
        clear_blk();
        send_blk(0, 0, 0, NSAMP, NSAMP - 1, 1);
        idle(1);
        // Single 0x4000 -> exp 9, mantissa 0x20
        clear_blk();
        vi[3] = 16'h4000; ei[3] = 7'h20;
        send_blk(0, 0, 9, NSAMP, NSAMP - 1, 1);
        // Saturated round and most-negative value, back-to-back
        clear_blk();
        vi[0] = 16'h7FFF; ei[0] = 7'h3F;
        vi[11] = 16'h8000; ei[11] = 7'h40;
        send_blk(0, 0, 9, NSAMP, NSAMP - 1, 1);
        idle(2);
        // Small values: exp 0, mantissas 5 and -3
        clear_blk();
        vi[2] = 16'h0005; ei[2] = 7'h05;
        vi[5] = 16'hFFFD; ei[5] = 7'h7D;
        send_blk(0, 0, 0, NSAMP, NSAMP - 1, 1);
        idle(1);
        // Fixed exponent 2: clamps both ways, in-range value 4
        clear_blk();
        vi[0] = 16'h0400; ei[0] = 7'h3F;
        vi[1] = 16'h0010; ei[1] = 7'h04;
        vi[2] = 16'hFC00; ei[2] = 7'h40;
        vq[4] = 16'h0100; eq[4] = 7'h3F;
        send_blk(1, 2, 2, NSAMP, NSAMP - 1, 1);
        // Fixed exponent 15 limited to 9; 0x0100 rounds half up to 1
        clear_blk();
        vi[0] = 16'h4000; ei[0] = 7'h20;
        vq[1] = 16'h0100; eq[1] = 7'h01;
        send_blk(1, 15, 9, NSAMP, NSAMP - 1, 1);
        idle(3);
        // Three gapless blocks: exp 1, 7, 0 (no carry-over of block 2's max)
        clear_blk();
        vi[0] = 16'h0040; ei[0] = 7'h20;
        send_blk(0, 0, 1, NSAMP, NSAMP - 1, 1);
        clear_blk();
        vi[5] = 16'h1000; ei[5] = 7'h20;
        vq[6] = 16'h0300; eq[6] = 7'h06;
        send_blk(0, 0, 7, NSAMP, NSAMP - 1, 1);
        clear_blk();
        vi[0] = 16'h0030; ei[0] = 7'h30;
        vq[3] = 16'hFFC0; eq[3] = 7'h40;
        send_blk(0, 0, 0, NSAMP, NSAMP - 1, 1);
        drain();
        chk("len_err_clean", 32'(o_len_err), 0);

        // Early eop on beat 7 -> sticky error; next block still correct
        clear_blk();
        vi[1] = 16'h1234;
        send_blk(0, 0, 0, 8, 7, 0);
        chk("len_err_set", 32'(o_len_err), 1);
        idle(2);
        clear_blk();
        vi[3] = 16'h4000; ei[3] = 7'h20;
        send_blk(0, 0, 9, NSAMP, NSAMP - 1, 1);
        drain();
        chk("len_err_held", 32'(o_len_err), 1);

        // Reset mid-block: everything cleared, no stale valid afterwards
        clear_blk();
        vi[0] = 16'h2000;
        send_blk(0, 0, 0, 6, NSAMP - 1, 0);
        q.delete();
        rst = 1;
        i_vld = 0; i_sop = 0; i_eop = 0;
        step();
        chk("mrst_dout", 32'(o_dout), 0);
        chk("mrst_exp", 32'(o_exp), 0);
        chk("mrst_len_err", 32'(o_len_err), 0);
        chk("mrst_sb", {o_sop, o_eop, o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info}, 0);
        rst = 0;
        idle(LAT + 4);
        clear_blk();
        vi[7] = 16'h0005; ei[7] = 7'h05;
        send_blk(0, 0, 0, NSAMP, NSAMP - 1, 1);
        drain();
        chk("len_err_after_rst", 32'(o_len_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
